// File: rtl/pattern_pkg.sv
// Shared state type and constants for the repeating-pattern serial transmitter.
package pattern_pkg;

   typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

   localparam int PAT_LEN = 5;
   localparam int IDX_W   = $clog2(PAT_LEN);

   localparam logic [PAT_LEN-1:0] PAT_DEFAULT = 5'b00101;

   // Line symbols: B is the low level, C the high (idle) level.
   localparam logic B = 1'b0;
   localparam logic C = 1'b1;

endpackage

// File: rtl/pattern_shift.sv
// Pattern shift register and bit index; the MSB flop drives the serial line directly.
module pattern_shift
   import pattern_pkg::*;
#(
   parameter logic [PAT_LEN-1:0] PAT = PAT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift,
   input  logic clear,
   output logic bit_out,
   output logic last
);

   logic [PAT_LEN-1:0] sreg;
   logic [IDX_W-1:0]   idx;

   // Idle-level fill means the register reads all-C whenever no pattern is loaded.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst || clear) begin
         sreg <= {PAT_LEN{C}};
         idx  <= '0;
      end else if (load) begin
         sreg <= PAT;
         idx  <= IDX_W'(PAT_LEN - 1);
      end else if (shift) begin
         sreg <= {sreg[PAT_LEN-2:0], C};
         idx  <= idx - IDX_W'(1);
      end
   end

   assign bit_out = sreg[PAT_LEN-1];
   assign last    = (idx == '0);

endmodule

// File: rtl/pattern_tx.sv
// Burst transmitter: sends PAT count times, MSB first, separated by gap idle cycles.
module pattern_tx
   import pattern_pkg::*;
#(
   parameter logic [PAT_LEN-1:0] PAT   = PAT_DEFAULT,
   parameter int                 CNT_W = 4,
   parameter int                 GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             dout,
   output logic             dvalid,
   output logic             busy,
   output logic             done
);

   state_t             state, state_d;
   logic [CNT_W-1:0]   rep_cnt;
   logic [GAP_W-1:0]   gap_lat;
   logic [GAP_W-1:0]   gap_cnt;
   logic               sh_load, sh_shift, sh_clear, sh_last;

   pattern_shift #(.PAT(PAT)) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (sh_load),
      .shift   (sh_shift),
      .clear   (sh_clear),
      .bit_out (dout),
      .last    (sh_last)
   );

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d  = state;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_clear = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  state_d = SEND;
                  sh_load = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         SEND: begin
            if (abort) begin
               state_d  = IDLE;
               sh_clear = 1'b1;
            end else if (!sh_last) begin
               sh_shift = 1'b1;
            end else if (rep_cnt == CNT_W'(1)) begin
               state_d  = FIN;
               sh_clear = 1'b1;
            end else if (gap_lat != '0) begin
               state_d  = GAP;
               sh_clear = 1'b1;
            end else begin
               sh_load = 1'b1;
            end
         end
         GAP: begin
            if (abort) begin
               state_d  = IDLE;
               sh_clear = 1'b1;
            end else if (gap_cnt == GAP_W'(1)) begin
               state_d = SEND;
               sh_load = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rep_cnt <= '0;
         gap_lat <= '0;
         gap_cnt <= '0;
         dvalid  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state  <= state_d;
         dvalid <= (state_d == SEND);
         busy   <= (state_d != IDLE);
         done   <= (state_d == FIN);

         if (state == IDLE && start) begin
            rep_cnt <= count;
            gap_lat <= gap;
         end else if (state == SEND && sh_last && !abort) begin
            // rep_cnt is at least 1 in SEND, so this never wraps.
            rep_cnt <= rep_cnt - CNT_W'(1);
         end

         if (state == SEND && state_d == GAP)
            gap_cnt <= gap_lat;
         else if (state == GAP)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

endmodule
